// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Good bytes go into a small first-word-fall-through FIFO; bad frames raise one error pulse.
module ps2_rx_ctrl #(
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int FIFO_DEPTH     = 4,
   parameter int FIFO_AW        = 2
) (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       PS2_CLK_DB,
   input  logic       PS2_DATA_DB,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic       RX_READY,
   output logic       ERR_PARITY,
   output logic       ERR_FRAME,
   output logic       ERR_OVERFLOW,
   output logic       BUSY
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   localparam logic [17:0]      TO_LAST = 18'(TIMEOUT_CYCLES - 1);
   localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

   state_t             state_q, state_d;
   logic               clk_prev_q;
   logic [2:0]         bitcnt_q, bitcnt_d;
   logic [7:0]         shreg_q, shreg_d;
   logic               par_q, par_d;
   logic [17:0]        timer_q, timer_d;
   logic               err_par_q, err_par_d;
   logic               err_frm_q, err_frm_d;
   logic               err_ovf_q, err_ovf_d;
   logic               push_req, push, pop, fall;
   logic [7:0]         mem_q [FIFO_DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_AW:0]   count_q;

   assign fall     = clk_prev_q & ~PS2_CLK_DB;
   assign RX_VALID = (count_q != '0);
   assign RX_DATA  = RX_VALID ? mem_q[rd_ptr_q] : 8'h00;
   assign pop      = RX_VALID & RX_READY;
   assign push     = push_req & ((count_q < DEPTH_C) | pop);
   assign BUSY     = (state_q != S_IDLE);

   assign ERR_PARITY   = err_par_q;
   assign ERR_FRAME    = err_frm_q;
   assign ERR_OVERFLOW = err_ovf_q;

   always_comb begin
      state_d   = state_q;
      bitcnt_d  = bitcnt_q;
      shreg_d   = shreg_q;
      par_d     = par_q;
      timer_d   = timer_q;
      err_par_d = 1'b0;
      err_frm_d = 1'b0;
      push_req  = 1'b0;
      if (state_q == S_IDLE) begin
         timer_d = '0;
         if (fall) begin
            if (!PS2_DATA_DB) begin
               state_d  = S_DATA;
               bitcnt_d = '0;
            end else begin
               err_frm_d = 1'b1;
            end
         end
      end else if (fall) begin
         // A falling edge always wins over an expiring timer.
         timer_d = '0;
         case (state_q)
            S_DATA: begin
               shreg_d  = {PS2_DATA_DB, shreg_q[7:1]};
               bitcnt_d = bitcnt_q + 3'd1;
               if (bitcnt_q == 3'd7) state_d = S_PARITY;
            end
            S_PARITY: begin
               par_d   = PS2_DATA_DB;
               state_d = S_STOP;
            end
            default: begin
               state_d = S_IDLE;
               if (!PS2_DATA_DB)               err_frm_d = 1'b1;
               else if (!(^{shreg_q, par_q}))  err_par_d = 1'b1;
               else                            push_req  = 1'b1;
            end
         endcase
      end else if (timer_q == TO_LAST) begin
         state_d   = S_IDLE;
         timer_d   = '0;
         err_frm_d = 1'b1;
      end else begin
         timer_d = timer_q + 18'd1;
      end
      err_ovf_d = push_req & ~push;
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_q    <= S_IDLE;
         clk_prev_q <= 1'b1;
         bitcnt_q   <= '0;
         shreg_q    <= '0;
         par_q      <= 1'b0;
         timer_q    <= '0;
         err_par_q  <= 1'b0;
         err_frm_q  <= 1'b0;
         err_ovf_q  <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         clk_prev_q <= PS2_CLK_DB;
         bitcnt_q   <= bitcnt_d;
         shreg_q    <= shreg_d;
         par_q      <= par_d;
         timer_q    <= timer_d;
         err_par_q  <= err_par_d;
         err_frm_q  <= err_frm_d;
         err_ovf_q  <= err_ovf_d;
         if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_q <= count_q - (FIFO_AW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset; only pointers and count define what is valid.
   always_ff @(posedge CLK) begin
      if (push) mem_q[wr_ptr_q] <= shreg_q;
   end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Scoreboard bench for ps2_rx_ctrl: stimulus predicts bytes and error kinds into queues,
// an independent monitor pops and compares whenever the DUT presents data or an error pulse.
module tb_ps2_rx_ctrl;

   localparam int TO = 100;
   localparam int E_PAR = 1, E_FRM = 2, E_OVF = 3;

   logic       CLK = 1'b0;
   logic       RESETN = 1'b0;
   logic       PS2_CLK_DB = 1'b1;
   logic       PS2_DATA_DB = 1'b1;
   logic       RX_READY = 1'b0;
   logic [7:0] RX_DATA;
   logic       RX_VALID, ERR_PARITY, ERR_FRAME, ERR_OVERFLOW, BUSY;

   int         n_chk = 0, n_fail = 0;
   int         cyc = 0, fall_cyc = 0, rise_cyc = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] exp_q [$];
   int         err_q [$];
   logic [7:0] mon_e;
   int         mon_code, mon_n;

   ps2_rx_ctrl #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
      .CLK(CLK), .RESETN(RESETN), .PS2_CLK_DB(PS2_CLK_DB), .PS2_DATA_DB(PS2_DATA_DB),
      .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
      .ERR_PARITY(ERR_PARITY), .ERR_FRAME(ERR_FRAME), .ERR_OVERFLOW(ERR_OVERFLOW), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the next rising edge whenever valid && ready here.
   always @(negedge CLK) begin
      if (RESETN) begin
         if (RX_VALID && !prev_valid) rise_cyc = cyc;
         prev_valid = RX_VALID;
         if (RX_VALID && RX_READY) begin
            if (exp_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_byte: got %0h, expected none", RX_DATA);
            end else begin
               mon_e = exp_q.pop_front();
               chk("rx_data", {24'h0, RX_DATA}, {24'h0, mon_e});
            end
         end
         if (!RX_VALID) chk("rx_data_zero_when_idle", {24'h0, RX_DATA}, 32'h0);
         mon_n = int'(ERR_PARITY) + int'(ERR_FRAME) + int'(ERR_OVERFLOW);
         if (mon_n > 1) chk("err_onehot", mon_n, 1);
         else if (mon_n == 1) begin
            mon_code = ERR_PARITY ? E_PAR : (ERR_FRAME ? E_FRM : E_OVF);
            if (err_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_error: got kind %0d, expected none", mon_code);
            end else chk("err_kind", mon_code, err_q.pop_front());
         end
      end else prev_valid = 1'b0;
   end

   // One PS/2 bit: data settles while the clock is high, then the clock falls.
   task automatic ps2_bit(input logic b, input logic rdy_pulse = 1'b0);
      int hp;
      hp = $urandom_range(2, 6);
      @(posedge CLK); #1 PS2_DATA_DB = b;
      repeat (hp) @(posedge CLK);
      #1 PS2_CLK_DB = 1'b0;
      fall_cyc = cyc;
      if (rdy_pulse) begin
         RX_READY = 1'b1;
         @(posedge CLK); #1 RX_READY = 1'b0;
         hp = hp - 1;
      end
      repeat (hp) @(posedge CLK);
      #1 PS2_CLK_DB = 1'b1;
   endtask

   function automatic logic good_par(input logic [7:0] b);
      return ($countones(b) % 2) == 0;
   endfunction

   // Reference model: decide the outcome of the frame from its bits and FIFO occupancy.
   task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                             input logic rdy_pulse = 1'b0);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      if (!stop)                                 err_q.push_back(E_FRM);
      else if ((($countones(b) + par) % 2) != 1) err_q.push_back(E_PAR);
      else if (exp_q.size() < 4 || RX_READY || rdy_pulse) exp_q.push_back(b);
      else                                       err_q.push_back(E_OVF);
      ps2_bit(stop, rdy_pulse);
   endtask

   task automatic drain();
      int n;
      RX_READY = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge CLK); n++;
      end
      repeat (3) @(posedge CLK);
      chk("drain_complete", exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] rb;
      logic       rp, rs;
      repeat (3) @(posedge CLK);
      #1;
      chk("reset_valid", RX_VALID, 0);
      chk("reset_data", RX_DATA, 0);
      chk("reset_busy", BUSY, 0);
      chk("reset_errs", {ERR_PARITY, ERR_FRAME, ERR_OVERFLOW}, 0);
      RESETN = 1'b1;
      repeat (3) @(posedge CLK);

      // Good 0x1C with consumer ready, latency check
      RX_READY = 1'b1;
      send_frame(8'h1C, 1'b0, 1'b1);
      chk("valid_latency", rise_cyc, fall_cyc + 1);
      chk("busy_after_stop", BUSY, 0);
      send_frame(8'h1C, 1'b1, 1'b1);
      send_frame(8'hF0, 1'b1, 1'b1);
      drain();

      // Stall mid-frame then timeout, then a clean frame
      ps2_bit(1'b0);
      for (int i = 0; i < 4; i++) ps2_bit(1'b1);
      err_q.push_back(E_FRM);
      chk("busy_during_stall", BUSY, 1);
      repeat (TO + 10) @(posedge CLK);
      #1 chk("busy_after_timeout", BUSY, 0);
      send_frame(8'h5A, 1'b1, 1'b1);
      drain();

      // Start bit 1 in idle, then bad stop with bad parity
      err_q.push_back(E_FRM);
      ps2_bit(1'b1);
      repeat (3) @(posedge CLK);
      #1 chk("busy_after_bad_start", BUSY, 0);
      send_frame(8'h1C, 1'b1, 1'b0);

      // Overflow with consumer stalled, ordered drain
      RX_READY = 1'b0;
      send_frame(8'h11, good_par(8'h11), 1'b1);
      send_frame(8'h22, good_par(8'h22), 1'b1);
      send_frame(8'h33, good_par(8'h33), 1'b1);
      send_frame(8'h44, good_par(8'h44), 1'b1);
      send_frame(8'h55, good_par(8'h55), 1'b1);
      drain();

      // Full FIFO with a pop coinciding with the push; a further push must overflow
      RX_READY = 1'b0;
      send_frame(8'hA1, good_par(8'hA1), 1'b1);
      send_frame(8'hA2, good_par(8'hA2), 1'b1);
      send_frame(8'hA3, good_par(8'hA3), 1'b1);
      send_frame(8'hA4, good_par(8'hA4), 1'b1);
      send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b1);
      chk("still_valid_after_simul", RX_VALID, 1);
      send_frame(8'hA6, good_par(8'hA6), 1'b1);
      drain();

      // Random frames with random consumer readiness and occasional corruption
      for (int k = 0; k < 40; k++) begin
         RX_READY = 1'($urandom_range(0, 1));
         rb = 8'($urandom);
         rp = ($urandom_range(0, 4) == 0) ? ~good_par(rb) : good_par(rb);
         rs = ($urandom_range(0, 9) != 0);
         send_frame(rb, rp, rs);
      end
      drain();

      // Mid-frame reset with bytes queued
      RX_READY = 1'b0;
      send_frame(8'h11, good_par(8'h11), 1'b1);
      send_frame(8'h22, good_par(8'h22), 1'b1);
      ps2_bit(1'b0);
      for (int i = 0; i < 5; i++) ps2_bit(1'b1);
      @(posedge CLK); #1 RESETN = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_mid_valid", RX_VALID, 0);
      chk("rst_mid_busy", BUSY, 0);
      chk("rst_mid_errs", {ERR_PARITY, ERR_FRAME, ERR_OVERFLOW}, 0);
      repeat (3) @(posedge CLK);
      #1 RESETN = 1'b1;
      repeat (2) @(posedge CLK);
      RX_READY = 1'b1;
      send_frame(8'h1C, 1'b0, 1'b1);
      drain();

      repeat (5) @(posedge CLK);
      chk("err_queue_empty", err_q.size(), 0);
      chk("final_busy", BUSY, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
